// File: rtl/sdram_pkg.sv
// Shared types and SDRAM command encodings for the command-bus arbiter.
// Commands are {cs_n, ras_n, cas_n, we_n}.
package sdram_pkg;

  typedef enum logic [2:0] {
    S_INIT  = 3'd0,
    S_IDLE  = 3'd1,
    S_AREF  = 3'd2,
    S_MREG  = 3'd3,
    S_WRITE = 3'd4,
    S_READ  = 3'd5
  } arb_state_t;

  localparam logic [3:0] CMD_NOP  = 4'b0111;
  localparam logic [3:0] CMD_ACT  = 4'b0011;
  localparam logic [3:0] CMD_RD   = 4'b0101;
  localparam logic [3:0] CMD_WR   = 4'b0100;
  localparam logic [3:0] CMD_PRE  = 4'b0010;
  localparam logic [3:0] CMD_AREF = 4'b0001;
  localparam logic [3:0] CMD_LMR  = 4'b0000;

endpackage

// File: rtl/sdram_refresh_timer.sv
// Periodic refresh scheduler: free-running interval counter plus the
// pending-refresh flag and the sticky missed-refresh flag.
module sdram_refresh_timer #(
  parameter int REF_INTERVAL = 780
) (
  input  logic sys_clk,
  input  logic sys_rst_n,
  input  logic i_en,
  input  logic i_clr,
  output logic o_ref_req,
  output logic o_ref_miss
);

  localparam int CNT_W = (REF_INTERVAL > 1) ? $clog2(REF_INTERVAL) : 1;

  logic [CNT_W-1:0] r_cnt;
  logic             r_ref_pend;
  logic             r_ref_miss;
  logic             w_wrap;

  assign w_wrap = i_en && (r_cnt == CNT_W'(REF_INTERVAL - 1));

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      r_cnt      <= '0;
      r_ref_pend <= 1'b0;
      r_ref_miss <= 1'b0;
    end else begin
      if (w_wrap)
        r_cnt <= '0;
      else if (i_en)
        r_cnt <= r_cnt + CNT_W'(1);

      // A wrap in the same cycle as the completion leaves a fresh request pending.
      if (w_wrap)
        r_ref_pend <= 1'b1;
      else if (i_clr)
        r_ref_pend <= 1'b0;

      if (w_wrap && r_ref_pend)
        r_ref_miss <= 1'b1;
    end
  end

  // The wrap cycle itself already counts as a request so the arbiter can
  // grant refresh ahead of other clients arbitrating in that same cycle.
  assign o_ref_req  = r_ref_pend | w_wrap;
  assign o_ref_miss = r_ref_miss;

endmodule

// File: rtl/sdram_cmd_arbiter.sv
// SDRAM command-bus owner: init pass-through, then a grant FSM with refresh
// priority and write/read round-robin.
//   state   | meaning
//   S_INIT  | init sequencer drives the pins until init_done
//   S_IDLE  | NOP on the pins, arbitrating the next grant
//   S_AREF  | auto-refresh granted, wait for aref_done
//   S_MREG  | load-mode-register granted, wait for mode_reg_done
//   S_WRITE | write engine granted, wait for wr_done
//   S_READ  | read engine granted, wait for rd_done
module sdram_cmd_arbiter
  import sdram_pkg::*;
#(
  parameter int REF_INTERVAL = 780,
  parameter int ADDR_W       = 12,
  parameter int BA_W         = 2
) (
  input  logic              sys_clk,
  input  logic              sys_rst_n,
  input  logic              init_done,
  input  logic [3:0]        init_cmd,
  input  logic [BA_W-1:0]   init_ba,
  input  logic [ADDR_W-1:0] init_addr,
  input  logic              mreg_req,
  output logic              mode_reg_en,
  input  logic              mode_reg_done,
  input  logic [3:0]        mreg_cmd,
  input  logic [BA_W-1:0]   mreg_ba,
  input  logic [ADDR_W-1:0] mreg_addr,
  output logic              aref_en,
  input  logic              aref_done,
  input  logic [3:0]        aref_cmd,
  input  logic [BA_W-1:0]   aref_ba,
  input  logic [ADDR_W-1:0] aref_addr,
  input  logic              wr_req,
  input  logic              rd_req,
  output logic              wr_en,
  output logic              rd_en,
  input  logic              wr_done,
  input  logic              rd_done,
  input  logic [3:0]        wr_cmd,
  input  logic [BA_W-1:0]   wr_ba,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [3:0]        rd_cmd,
  input  logic [BA_W-1:0]   rd_ba,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [3:0]        sdram_cmd,
  output logic [BA_W-1:0]   sdram_ba,
  output logic [ADDR_W-1:0] sdram_addr,
  output logic              ref_miss
);

  arb_state_t r_state;
  arb_state_t w_state_nxt;
  logic       r_last_wr;
  logic       w_last_wr_nxt;
  logic       r_aref_en, r_mreg_en, r_wr_en, r_rd_en;
  logic       w_ref_req;
  logic       w_aref_clr;

  assign w_aref_clr = aref_done && (r_state == S_AREF);

  sdram_refresh_timer #(
    .REF_INTERVAL (REF_INTERVAL)
  ) u_ref_timer (
    .sys_clk    (sys_clk),
    .sys_rst_n  (sys_rst_n),
    .i_en       (r_state != S_INIT),
    .i_clr      (w_aref_clr),
    .o_ref_req  (w_ref_req),
    .o_ref_miss (ref_miss)
  );

  always_comb begin
    w_state_nxt   = r_state;
    w_last_wr_nxt = r_last_wr;
    case (r_state)
      S_INIT:  if (init_done) w_state_nxt = S_IDLE;
      S_IDLE: begin
        if (w_ref_req)
          w_state_nxt = S_AREF;
        else if (mreg_req)
          w_state_nxt = S_MREG;
        else if (wr_req && (!rd_req || !r_last_wr)) begin
          w_state_nxt   = S_WRITE;
          w_last_wr_nxt = 1'b1;
        end else if (rd_req) begin
          w_state_nxt   = S_READ;
          w_last_wr_nxt = 1'b0;
        end
      end
      S_AREF:  if (aref_done)     w_state_nxt = S_IDLE;
      S_MREG:  if (mode_reg_done) w_state_nxt = S_IDLE;
      S_WRITE: if (wr_done)       w_state_nxt = S_IDLE;
      S_READ:  if (rd_done)       w_state_nxt = S_IDLE;
      default: w_state_nxt = S_INIT;
    endcase
  end

  // Reset leaves last_rw at "read" so write wins the first tie.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      r_state   <= S_INIT;
      r_last_wr <= 1'b0;
      r_aref_en <= 1'b0;
      r_mreg_en <= 1'b0;
      r_wr_en   <= 1'b0;
      r_rd_en   <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_last_wr <= w_last_wr_nxt;
      r_aref_en <= (w_state_nxt == S_AREF);
      r_mreg_en <= (w_state_nxt == S_MREG);
      r_wr_en   <= (w_state_nxt == S_WRITE);
      r_rd_en   <= (w_state_nxt == S_READ);
    end
  end

  assign aref_en     = r_aref_en;
  assign mode_reg_en = r_mreg_en;
  assign wr_en       = r_wr_en;
  assign rd_en       = r_rd_en;

  always_comb begin
    sdram_cmd  = CMD_NOP;
    sdram_ba   = '0;
    sdram_addr = '0;
    case (r_state)
      S_INIT:  begin sdram_cmd = init_cmd; sdram_ba = init_ba; sdram_addr = init_addr; end
      S_AREF:  begin sdram_cmd = aref_cmd; sdram_ba = aref_ba; sdram_addr = aref_addr; end
      S_MREG:  begin sdram_cmd = mreg_cmd; sdram_ba = mreg_ba; sdram_addr = mreg_addr; end
      S_WRITE: begin sdram_cmd = wr_cmd;   sdram_ba = wr_ba;   sdram_addr = wr_addr;   end
      S_READ:  begin sdram_cmd = rd_cmd;   sdram_ba = rd_ba;   sdram_addr = rd_addr;   end
      default: ;
    endcase
  end

endmodule

// File: doc/sdram_cmd_arbiter.md
# sdram_cmd_arbiter

Owns the SDRAM command bus after power-up and shares it between the command-generating sub-modules: init sequencer, load-mode-register, auto-refresh, write and read engines. Hands the bus to the init sequencer until `init_done`, then runs a grant state machine with a built-in periodic refresh scheduler. It muxes the granted client's `{cmd, ba, addr}` onto the SDRAM pins and drives NOP otherwise. Sits between the client modules and the SDRAM device (or `sdram_model_plus` in simulation).

## Interface

**Parameters**
- `REF_INTERVAL`, 780: sys_clk cycles between refresh requests (7.8 µs at 100 MHz).
- `ADDR_W`, 12: SDRAM address width.
- `BA_W`, 2: bank address width.

**Ports**
- `sys_clk`  in  1  system clock. One clock domain.
- `sys_rst_n`  in  1  asynchronous, active-low reset.
- `init_done`  in  1  init sequencer finished (level).
- `init_cmd`/`init_ba`/`init_addr`  in  4/BA_W/ADDR_W  init sequencer bus.
- `mreg_req`  in  1  request to reload the mode register (level).
- `mode_reg_en`  out  1  grant to load-mode-register.
- `mode_reg_done`  in  1  one-cycle completion pulse.
- `mreg_cmd`/`mreg_ba`/`mreg_addr`  in  4/BA_W/ADDR_W  load-mode-register bus.
- `aref_en`  out  1  grant to auto-refresh.
- `aref_done`  in  1  completion pulse.
- `aref_cmd`/`aref_ba`/`aref_addr`  in  auto-refresh bus.
- `wr_req`, `rd_req`  in  1  write/read requests (level).
- `wr_en`, `rd_en`  out  1  grants.
- `wr_done`, `rd_done`  in  1  completion pulses.
- `wr_cmd`/`wr_ba`/`wr_addr`, `rd_cmd`/`rd_ba`/`rd_addr`  in  write/read buses.
- `sdram_cmd`  out  4  `{cs_n, ras_n, cas_n, we_n}`.
- `sdram_ba`  out  BA_W.
- `sdram_addr`  out  ADDR_W.
- `ref_miss`  out  1  sticky: a refresh interval expired while a refresh was still pending.

## Operation

- States: `S_INIT`, `S_IDLE`, `S_AREF`, `S_MREG`, `S_WRITE`, `S_READ`.
- **S_INIT**
  - Output bus = init bus (pass-through).
  - Goes to `S_IDLE` on the edge where `init_done` = 1.
- **S_IDLE**
  - Output bus = NOP (`4'b0111`, ba 0, addr 0).
  - Fixed priority: refresh pending > `mreg_req` > write/read.
  - Write vs read: round-robin via `last_rw`. When both `wr_req` and `rd_req` are high, the one not served last wins. A single requester is always granted.
- **Granted states**
  - Exactly one `*_en` is high.
  - Output bus = that client's bus.
  - Stay in the state until that client's done pulse, then go to `S_IDLE`. The `*_en` drops on the same edge.
  - Requests dropped mid-grant are ignored; the arbiter waits for done.
  - Done pulses from non-granted clients are ignored.
- **Refresh timer**
  - Free-running counter, enabled once `init_done` is seen; counts 0..REF_INTERVAL-1 and wraps.
  - At wrap: set `ref_pend`. If `ref_pend` is already set, set `ref_miss` instead (no queuing of multiple refreshes).
  - `aref_done` clears `ref_pend`.
  - If wrap and `aref_done` occur in the same cycle, `ref_pend` ends set.
- `ref_miss` clears only on reset.

## Timing

- Reset values:
  - state `S_INIT`
  - all `*_en` 0
  - counter 0, `ref_pend` 0, `ref_miss` 0
  - `last_rw` = read (write wins the first tie)
  - sdram bus = init bus (pass-through)
- State, enables, counter and flags are registered. The output bus mux is combinational from the state register. The client's bus reaches the pins in the same cycle its `*_en` is high.
- Grant latency: request high in `S_IDLE` at edge N → `*_en` high after edge N.
- Done at edge M → `S_IDLE` after M. Earliest next grant is after M+1, so there is at least one NOP cycle between clients.
- Reset asserted mid-operation: immediate return to `S_INIT`, enables low, timer stopped and cleared.
- `init_done` falling after init has no effect.

## Structure

- Package `sdram_pkg` holds:
  - state enum `arb_state_t`
  - command constants `CMD_NOP = 4'b0111`, `CMD_AREF`, `CMD_LMR`, `CMD_PRE`, `CMD_ACT`, `CMD_RD`, `CMD_WR`
- Sub-module `sdram_refresh_timer` (counter plus `ref_pend`/`ref_miss` logic). The parent instantiates it once.

## Test plan

- Reset 5 cycles, `init_cmd = 4'b0001` held, `init_done` = 1 at cycle 10 → pins show `0001` until cycle 10, then NOP. No enable is high during init.
- After init, pulse `mreg_req`; bench pulses `mode_reg_done` 3 cycles after the grant → `mode_reg_en` high for exactly 3 cycles, pins follow `mreg_*`, then NOP for at least 1 cycle.
- `wr_req` and `rd_req` both held continuously, each done 4 cycles after its grant → grants alternate W, R, W, R starting with write.
- `REF_INTERVAL` = 20 with `wr_req` held and `wr_done` never pulsed → `ref_pend` set at cycle 20, `aref_en` stays 0, `ref_miss` = 1 at cycle 40. After `wr_done`, `aref_en` asserts next cycle, ahead of the still-high `wr_req`.
- Refresh wrap, `mreg_req` and `wr_req` all in the same `S_IDLE` cycle → `aref_en` first, then `mode_reg_en`, then `wr_en`.
- Reset asserted while `S_WRITE` is active → `wr_en` = 0 and pins pass through the init bus immediately. After deassertion the arbiter waits for `init_done` again.
